clock_set_ctrl: RTL and testbench

Mode and sequencing controller for the hh:mm:ss timekeeping counter. It turns debounced button pulses into a set-time / set-alarm state machine. It pauses the counter while time is being edited and loads the edited time back with a one-cycle pulse. It also holds an alarm register, compares it with the running time, and drives the display-select and blink outputs.

---
 rtl/clock_set_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the hh:mm:ss counter: set-time and set-alarm
// state machine, load pulse generation, alarm compare, display select and blink.
module clock_set_ctrl #(
  parameter int HOUR_MAX  = 23,
  parameter int MIN_MAX   = 59,
  parameter int ALARM_LEN = 60,
  parameter int TIMEOUT   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [2:0] mode,
  output logic [4:0] disp_hour,
  output logic [5:0] disp_min,
  output logic       blink,
  output logic       alarm_armed,
  output logic       alarm_on
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] AL_LEN  = AW'(ALARM_LEN);
  localparam logic [4:0]    HMAX    = 5'(HOUR_MAX);
  localparam logic [5:0]    MMAX    = 6'(MIN_MAX);

  typedef enum logic [2:0] {
    S_RUN         = 3'd0,
    S_SET_HOUR    = 3'd1,
    S_SET_MIN     = 3'd2,
    S_SET_AL_HOUR = 3'd3,
    S_SET_AL_MIN  = 3'd4
  } state_t;

  state_t        r_state;
  logic [4:0]    r_edit_hour, r_al_hour, r_load_hour;
  logic [5:0]    r_edit_min, r_al_min, r_load_min;
  logic          r_load, r_blink, r_armed, r_alarm_on;
  logic [TW-1:0] r_to;
  logic [AW-1:0] r_alen;

  logic w_set, w_any_btn, w_consume, w_mode, w_inc, w_match, w_trigger, w_timeout;

  function automatic logic [4:0] wrap_hour(input logic [4:0] h);
    wrap_hour = (h >= HMAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] wrap_min(input logic [5:0] m);
    wrap_min = (m >= MMAX) ? 6'd0 : m + 6'd1;
  endfunction

  // A press while the alarm sounds only silences it; mode beats inc.
  assign w_set     = (r_state != S_RUN);
  assign w_any_btn = btn_mode | btn_inc;
  assign w_consume = r_alarm_on & w_any_btn;
  assign w_mode    = btn_mode & ~w_consume;
  assign w_inc     = btn_inc & ~btn_mode & ~w_consume;
  assign run_en    = (r_state != S_SET_HOUR) && (r_state != S_SET_MIN);
  assign w_match   = (cur_hour == r_al_hour) && (cur_min == r_al_min) && (cur_sec == 6'd0);
  assign w_trigger = tick & r_armed & run_en & w_match;
  assign w_timeout = w_set & tick & ~w_any_btn & (r_to == TO_LAST);

  assign mode        = r_state;
  assign load        = r_load;
  assign load_hour   = r_load_hour;
  assign load_min    = r_load_min;
  assign load_sec    = 6'd0;
  assign blink       = r_blink;
  assign alarm_armed = r_armed;
  assign alarm_on    = r_alarm_on;

  always_comb begin
    disp_hour = cur_hour;
    disp_min  = cur_min;
    case (r_state)
      S_SET_HOUR, S_SET_MIN: begin
        disp_hour = r_edit_hour;
        disp_min  = r_edit_min;
      end
      S_SET_AL_HOUR, S_SET_AL_MIN: begin
        disp_hour = r_al_hour;
        disp_min  = r_al_min;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_edit_hour <= 5'd0;
      r_edit_min  <= 6'd0;
      r_al_hour   <= 5'd0;
      r_al_min    <= 6'd0;
      r_load      <= 1'b0;
      r_load_hour <= 5'd0;
      r_load_min  <= 6'd0;
      r_blink     <= 1'b0;
      r_armed     <= 1'b0;
      r_alarm_on  <= 1'b0;
      r_to        <= '0;
      r_alen      <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_mode) begin
            r_state     <= S_SET_HOUR;
            r_edit_hour <= cur_hour;
            r_edit_min  <= cur_min;
          end else if (w_inc) begin
            r_armed <= ~r_armed;
          end
        end
        S_SET_HOUR: begin
          if (w_mode)     r_state     <= S_SET_MIN;
          else if (w_inc) r_edit_hour <= wrap_hour(r_edit_hour);
        end
        S_SET_MIN: begin
          if (w_mode) begin
            r_state     <= S_SET_AL_HOUR;
            r_load      <= 1'b1;
            r_load_hour <= r_edit_hour;
            r_load_min  <= r_edit_min;
          end else if (w_inc) begin
            r_edit_min <= wrap_min(r_edit_min);
          end
        end
        S_SET_AL_HOUR: begin
          if (w_mode)     r_state   <= S_SET_AL_MIN;
          else if (w_inc) r_al_hour <= wrap_hour(r_al_hour);
        end
        S_SET_AL_MIN: begin
          if (w_mode)     r_state  <= S_RUN;
          else if (w_inc) r_al_min <= wrap_min(r_al_min);
        end
        default: r_state <= S_RUN;
      endcase
      // Abandoned edits fall back to RUN without a load pulse.
      if (w_timeout) r_state <= S_RUN;

      if (!w_set || w_any_btn || w_timeout) r_to <= '0;
      else if (tick)                        r_to <= r_to + TW'(1);

      if (!w_set || w_mode || w_timeout) r_blink <= 1'b0;
      else if (tick)                     r_blink <= ~r_blink;

      if (w_trigger) begin
        r_alarm_on <= 1'b1;
        r_alen     <= AL_LEN;
      end else if (w_consume) begin
        r_alarm_on <= 1'b0;
        r_alen     <= '0;
      end else if (r_alarm_on && tick) begin
        if (r_alen <= AW'(1)) begin
          r_alarm_on <= 1'b0;
          r_alen     <= '0;
        end else begin
          r_alen <= r_alen - AW'(1);
        end
      end
      // Disarming silences an alarm that is sounding.
      if (r_state == S_RUN && w_inc && r_armed) begin
        r_alarm_on <= 1'b0;
        r_alen     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_clock_set_ctrl;
  localparam int HOUR_MAX = 23, MIN_MAX = 59, ALARM_LEN = 60, TIMEOUT = 30;

  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic run_en, load, blink, alarm_armed, alarm_on;
  logic [4:0] load_hour, disp_hour;
  logic [5:0] load_min, load_sec, disp_min;
  logic [2:0] mode;

  int checks = 0, errors = 0;

  // Behavioural model state
  int m_mode, m_eh, m_em, m_ah, m_am, m_armed, m_aon, m_alen, m_to, m_blink;
  int m_load, m_lh, m_lm;

  always #5 clk = ~clk;

  clock_set_ctrl #(.HOUR_MAX(HOUR_MAX), .MIN_MAX(MIN_MAX), .ALARM_LEN(ALARM_LEN),
                   .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
    .load_sec(load_sec), .mode(mode), .disp_hour(disp_hour), .disp_min(disp_min),
    .blink(blink), .alarm_armed(alarm_armed), .alarm_on(alarm_on)
  );

  task automatic model_reset();
    m_mode = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0; m_armed = 0; m_aon = 0;
    m_alen = 0; m_to = 0; m_blink = 0; m_load = 0; m_lh = 0; m_lm = 0;
  endtask

  task automatic model_step(input int bm, input int bi, input int tk);
    int in_set, moving, trig, consume, mo, inc, nmode;
    in_set  = (m_mode != 0);
    moving  = (m_mode != 1 && m_mode != 2);
    trig    = tk && m_armed && moving && int'(cur_hour) == m_ah &&
              int'(cur_min) == m_am && cur_sec == 0;
    consume = m_aon && (bm || bi);
    mo      = bm && !consume;
    inc     = bi && !bm && !consume;
    nmode   = m_mode;
    m_load  = 0;
    if (mo) begin
      nmode = (m_mode + 1) % 5;
      if (m_mode == 0) begin m_eh = cur_hour; m_em = cur_min; end
      if (m_mode == 2) begin m_load = 1; m_lh = m_eh; m_lm = m_em; end
    end else if (inc) begin
      case (m_mode)
        0: m_armed = !m_armed;
        1: m_eh = (m_eh + 1) % (HOUR_MAX + 1);
        2: m_em = (m_em + 1) % (MIN_MAX + 1);
        3: m_ah = (m_ah + 1) % (HOUR_MAX + 1);
        default: m_am = (m_am + 1) % (MIN_MAX + 1);
      endcase
    end
    if (!in_set || bm || bi) m_to = 0;
    else if (tk) begin
      m_to++;
      if (m_to == TIMEOUT) begin nmode = 0; m_to = 0; end
    end
    if (trig) begin m_aon = 1; m_alen = ALARM_LEN; end
    else if (consume) begin m_aon = 0; m_alen = 0; end
    else if (m_aon && tk) begin
      m_alen--;
      if (m_alen == 0) m_aon = 0;
    end
    if (inc && m_mode == 0 && !m_armed) begin m_aon = 0; m_alen = 0; end
    if (nmode != m_mode || nmode == 0) m_blink = 0;
    else if (tk) m_blink = !m_blink;
    m_mode = nmode;
  endtask

  function automatic int exp_dh();
    if (m_mode == 0) return int'(cur_hour);
    if (m_mode <= 2) return m_eh;
    return m_ah;
  endfunction

  function automatic int exp_dm();
    if (m_mode == 0) return int'(cur_min);
    if (m_mode <= 2) return m_em;
    return m_am;
  endfunction

  task automatic cyc(input int bm, input int bi, input int tk);
    btn_mode = (bm != 0); btn_inc = (bi != 0); tick = (tk != 0);
    model_step(bm, bi, tk);
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0; tick = 1'b0;
  endtask

  task automatic press(input int bm, input int bi);
    cyc(bm, bi, 0);
    cyc(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mode !== 3'd0 || run_en !== 1'b1 || load !== 1'b0 || alarm_on !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold mode=%0d run_en=%0d load=%0d alarm_on=%0d want 0/1/0/0",
               mode, run_en, load, alarm_on);
    end
    rst = 1'b1;
    cyc(0, 0, 0);
    checks++;
    if (mode !== 3'd0 || run_en !== 1'b1 || load !== 1'b0 || alarm_armed !== 1'b0 ||
        blink !== 1'b0 || load_hour !== 5'd0 || load_min !== 6'd0 || load_sec !== 6'd0) begin
      errors++;
      $display("FAIL reset_release mode=%0d run_en=%0d load=%0d armed=%0d blink=%0d lh=%0d lm=%0d",
               mode, run_en, load, alarm_armed, blink, load_hour, load_min);
    end
    checks++;
    if (disp_hour !== 5'd12 || disp_min !== 6'd34) begin
      errors++;
      $display("FAIL reset_disp got %0d:%0d want 12:34", disp_hour, disp_min);
    end
  endtask

  task automatic run_set_seq(input int h, input int m, input int nh, input int nm,
                             input string tag);
    int seq[$];
    int loads, lh, lm, ls;
    loads = 0; lh = -1; lm = -1; ls = -1;
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'd0;
    seq.push_back(2);
    for (int k = 0; k < nh; k++) seq.push_back(1);
    seq.push_back(2);
    for (int k = 0; k < nm; k++) seq.push_back(1);
    seq.push_back(2);
    for (int k = 0; k < 2 * seq.size(); k++) begin
      if (k % 2 == 0) cyc(seq[k/2] == 2, seq[k/2] == 1, 0);
      else cyc(0, 0, 0);
      checks++;
      if (run_en !== (m_mode != 1 && m_mode != 2) || mode !== 3'(m_mode)) begin
        errors++;
        $display("FAIL %s_run_en step %0d run_en=%0d mode=%0d want mode %0d", tag, k,
                 run_en, mode, m_mode);
      end
      if (load === 1'b1) begin loads++; lh = load_hour; lm = load_min; ls = load_sec; end
    end
    checks++;
    if (mode !== 3'd3 || loads != 1) begin
      errors++;
      $display("FAIL %s_end mode=%0d loads=%0d want 3/1", tag, mode, loads);
    end
    checks++;
    if (lh != (h + nh) % (HOUR_MAX + 1) || lm != (m + nm) % (MIN_MAX + 1) || ls != 0) begin
      errors++;
      $display("FAIL %s_load got %0d:%0d:%0d want %0d:%0d:0", tag, lh, lm, ls,
               (h + nh) % (HOUR_MAX + 1), (m + nm) % (MIN_MAX + 1));
    end
    press(1, 0); press(1, 0);
    checks++;
    if (mode !== 3'd0 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL %s_back mode=%0d run_en=%0d want 0/1", tag, mode, run_en);
    end
  endtask

  task automatic test_set_time();
    run_set_seq(10, 15, 3, 50, "set_time");
    checks++;
    if (m_lh != 13 || m_lm != 5) begin
      errors++;
      $display("FAIL set_time_model got %0d:%0d want 13:5", m_lh, m_lm);
    end
    for (int r = 0; r < 3; r++)
      run_set_seq($urandom_range(HOUR_MAX), $urandom_range(MIN_MAX),
                  $urandom_range(30), $urandom_range(70), "set_rand");
  endtask

  task automatic test_hour_wrap();
    cur_hour = 5'd22; cur_min = 6'd0;
    press(1, 0);
    repeat (3) press(0, 1);
    checks++;
    if (disp_hour !== 5'd1 || mode !== 3'd1) begin
      errors++;
      $display("FAIL hour_wrap disp_hour=%0d mode=%0d want 1/1", disp_hour, mode);
    end
    repeat (4) press(1, 0);
    checks++;
    if (mode !== 3'd0) begin
      errors++;
      $display("FAIL hour_wrap_exit mode=%0d want 0", mode);
    end
  endtask

  task automatic test_simultaneous();
    cur_hour = 5'd5; cur_min = 6'd20;
    press(1, 0);
    press(1, 1);
    checks++;
    if (mode !== 3'd2 || disp_hour !== 5'd5 || disp_min !== 6'd20) begin
      errors++;
      $display("FAIL simul mode=%0d disp=%0d:%0d want 2 and 5:20", mode, disp_hour, disp_min);
    end
    repeat (3) press(1, 0);
    checks++;
    if (mode !== 3'd0) begin
      errors++;
      $display("FAIL simul_exit mode=%0d want 0", mode);
    end
  endtask

  task automatic test_alarm();
    int held;
    cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    repeat (3) press(1, 0);
    repeat (7) press(0, 1);
    checks++;
    if (mode !== 3'd3 || disp_hour !== 5'd7 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL alarm_hour mode=%0d disp_hour=%0d run_en=%0d want 3/7/1",
               mode, disp_hour, run_en);
    end
    press(1, 0);
    repeat (30) press(0, 1);
    checks++;
    if (disp_hour !== 5'd7 || disp_min !== 6'd30) begin
      errors++;
      $display("FAIL alarm_min disp=%0d:%0d want 7:30", disp_hour, disp_min);
    end
    press(1, 0);
    press(0, 1);
    checks++;
    if (mode !== 3'd0 || alarm_armed !== 1'b1 || alarm_on !== 1'b0) begin
      errors++;
      $display("FAIL alarm_arm mode=%0d armed=%0d on=%0d want 0/1/0", mode, alarm_armed, alarm_on);
    end
    // Full-length ring
    cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0;
    cyc(0, 0, 1);
    checks++;
    if (alarm_on !== 1'b1) begin
      errors++;
      $display("FAIL alarm_fire alarm_on=%0d want 1", alarm_on);
    end
    cur_sec = 6'd1;
    held = 0;
    for (int i = 0; i < ALARM_LEN - 1; i++) begin
      cyc(0, 0, 1); cyc(0, 0, 0);
      if (alarm_on === 1'b1) held++;
    end
    checks++;
    if (held != ALARM_LEN - 1) begin
      errors++;
      $display("FAIL alarm_hold held %0d ticks want %0d", held, ALARM_LEN - 1);
    end
    cyc(0, 0, 1);
    checks++;
    if (alarm_on !== 1'b0 || alarm_armed !== 1'b1) begin
      errors++;
      $display("FAIL alarm_expire on=%0d armed=%0d want 0/1", alarm_on, alarm_armed);
    end
    // Re-match restarts the length count
    cur_sec = 6'd0; cyc(0, 0, 1); cur_sec = 6'd1;
    repeat (10) begin cyc(0, 0, 1); cyc(0, 0, 0); end
    cur_sec = 6'd0; cyc(0, 0, 1); cur_sec = 6'd1;
    held = 0;
    for (int i = 0; i < ALARM_LEN - 1; i++) begin
      cyc(0, 0, 1);
      if (alarm_on === 1'b1) held++;
    end
    cyc(0, 0, 1);
    checks++;
    if (held != ALARM_LEN - 1 || alarm_on !== 1'b0) begin
      errors++;
      $display("FAIL alarm_restart held %0d on=%0d want %0d/0", held, alarm_on, ALARM_LEN - 1);
    end
    // Button silences the alarm without disarming
    cur_sec = 6'd0; cyc(0, 0, 1); cur_sec = 6'd1;
    repeat (4) cyc(0, 0, 1);
    cyc(0, 1, 1);
    checks++;
    if (alarm_on !== 1'b0 || alarm_armed !== 1'b1 || mode !== 3'd0) begin
      errors++;
      $display("FAIL alarm_clear on=%0d armed=%0d mode=%0d want 0/1/0", alarm_on, alarm_armed, mode);
    end
  endtask

  task automatic test_timeout();
    int loads;
    loads = 0;
    cur_hour = 5'd3; cur_min = 6'd3; cur_sec = 6'd3;
    press(1, 0); press(1, 0);
    checks++;
    if (mode !== 3'd2 || run_en !== 1'b0) begin
      errors++;
      $display("FAIL timeout_enter mode=%0d run_en=%0d want 2/0", mode, run_en);
    end
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cyc(0, 0, 1);
      if (load === 1'b1) loads++;
      cyc(0, 0, 0);
    end
    checks++;
    if (mode !== 3'd2 || blink !== 1'(m_blink)) begin
      errors++;
      $display("FAIL timeout_wait mode=%0d blink=%0d want 2/%0d", mode, blink, m_blink);
    end
    cyc(0, 0, 1);
    if (load === 1'b1) loads++;
    cyc(0, 0, 0);
    if (load === 1'b1) loads++;
    checks++;
    if (mode !== 3'd0 || run_en !== 1'b1 || loads != 0 || blink !== 1'b0) begin
      errors++;
      $display("FAIL timeout_exit mode=%0d run_en=%0d loads=%0d blink=%0d want 0/1/0/0",
               mode, run_en, loads, blink);
    end
    checks++;
    if (disp_hour !== 5'd3 || disp_min !== 6'd3) begin
      errors++;
      $display("FAIL timeout_disp got %0d:%0d want 3:3", disp_hour, disp_min);
    end
    // Reset arriving while a load pulse is out
    press(1, 0); press(1, 0);
    cyc(1, 0, 0);
    checks++;
    if (load !== 1'b1 || load_hour !== 5'd3 || mode !== 3'd3) begin
      errors++;
      $display("FAIL reset_pre load=%0d lh=%0d mode=%0d want 1/3/3", load, load_hour, mode);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (load !== 1'b0 || mode !== 3'd0 || run_en !== 1'b1 || alarm_armed !== 1'b0 ||
        load_hour !== 5'd0 || blink !== 1'b0) begin
      errors++;
      $display("FAIL reset_async load=%0d mode=%0d run_en=%0d armed=%0d lh=%0d blink=%0d",
               load, mode, run_en, alarm_armed, load_hour, blink);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] got, want;
    for (int i = 0; i < 1500; i++) begin
      int r;
      if ($urandom_range(3) == 0) begin
        cur_hour = 5'(m_ah); cur_min = 6'(m_am);
        cur_sec = ($urandom_range(2) == 0) ? 6'd0 : 6'($urandom_range(MIN_MAX));
      end else begin
        cur_hour = 5'($urandom_range(HOUR_MAX));
        cur_min  = 6'($urandom_range(MIN_MAX));
        cur_sec  = 6'($urandom_range(MIN_MAX));
      end
      r = $urandom_range(15);
      cyc(r == 0 || r == 2, r == 1 || r == 2 || r == 3, $urandom_range(2) == 0);
      got  = {mode, run_en, load, load_hour, load_min, disp_hour, disp_min, blink,
              alarm_armed, alarm_on, 1'b0};
      want = {3'(m_mode), 1'(m_mode != 1 && m_mode != 2), 1'(m_load), 5'(m_lh), 6'(m_lm),
              5'(exp_dh()), 6'(exp_dm()), 1'(m_blink), 1'(m_armed), 1'(m_aon), 1'b0};
      checks++;
      if (got !== want || load_sec !== 6'd0) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_hour_wrap();
    test_simultaneous();
    test_alarm();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
